// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, legality check and arbiter FSM states.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic alu_op_legal(input alu_op_t op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above the pointer,
// wrapping modulo NREQ. Produces both a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    logic [IW:0] j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so ptr+k can exceed NREQ-1 before the wrap.
      j = {1'b0, i_ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
      if (!o_any && i_req[j[IW-1:0]]) begin
        o_any              = 1'b1;
        o_grant[j[IW-1:0]] = 1'b1;
        o_idx              = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters.
// Optional op-code checking with rsp_err output: define ALU_ARB_OPCHK_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]  rsp_valid,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [W-1:0]     rsp_s,
  output logic             rsp_zero,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [W-1:0]     alu_s,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_ARB_OPCHK_EN
  ,
  output logic             rsp_err
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_t    r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_gidx;
  logic [W-1:0]  r_alu_a;
  logic [W-1:0]  r_alu_b;
  alu_op_t       r_alu_ctrl;
  logic [W-1:0]  r_s;
  logic          r_zero;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  alu_op_t         w_sel_op;
  logic            w_rsp_hs;
  logic [IW-1:0]   w_ptr_nxt;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == IW'(i)) begin
        w_sel_a  = req_a[i*W +: W];
        w_sel_b  = req_b[i*W +: W];
        w_sel_op = req_op[i*4 +: 4];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      rsp_valid[i] = (r_state == RESP) && (r_gidx == IW'(i));
  end

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_rsp_hs  = (r_state == RESP) && rsp_ready[r_gidx];
  assign w_ptr_nxt = (r_gidx == IW'(NREQ-1)) ? '0 : r_gidx + 1'b1;
  assign busy      = (r_state != IDLE);
  assign rsp_s     = r_s;
  assign rsp_zero  = r_zero;
  // ALU inputs come straight from the operand latches, so they hold between ops.
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;

`ifdef ALU_ARB_OPCHK_EN
  logic r_err;
  assign rsp_err = r_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_ctrl <= '0;
      r_s        <= '0;
      r_zero     <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_alu_a    <= w_sel_a;
          r_alu_b    <= w_sel_b;
          r_alu_ctrl <= w_sel_op;
          r_gidx     <= w_gidx;
          r_state    <= EXEC;
        end
        EXEC: begin
`ifdef ALU_ARB_OPCHK_EN
          if (!alu_op_legal(r_alu_ctrl)) begin
            r_s    <= '0;
            r_zero <= 1'b1;
            r_err  <= 1'b1;
          end else begin
            r_s    <= alu_s;
            r_zero <= alu_zero;
            r_err  <= 1'b0;
          end
`else
          r_s    <= alu_s;
          r_zero <= alu_zero;
`endif
          r_state <= RESP;
        end
        RESP: if (w_rsp_hs) begin
          r_ptr   <= w_ptr_nxt;
          r_state <= IDLE;
`ifdef ALU_ARB_OPCHK_EN
          r_err   <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between NREQ independent requesters, e.g. the main datapath plus the branch-compare and address-generation helpers.
- Each request is accepted on a valid/ready handshake and operands are registered. The block then drives the ALU, captures S/zero, and returns the result on a per-requester response handshake.
- Arbitration is round-robin.
- The ALU is external to this block: the block drives its A/B/ControlSig inputs and samples its S/zero outputs.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- W, 8, operand/result width; must match the ALU width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request i presents an operation.
- req_ready  out  NREQ  one-hot; request i accepted this cycle.
- req_a  in  NREQ*W  operand A, packed, requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B, packed.
- req_op  in  NREQ*4  ALU control code, packed.
- rsp_valid  out  NREQ  one-hot; result for requester i is valid.
- rsp_ready  in  NREQ  requester i consumes its result.
- rsp_s  out  W  result, shared bus, meaningful only while rsp_valid is nonzero.
- rsp_zero  out  1  zero flag of the result.
- alu_a, alu_b  out  W  to ALU A/B.
- alu_ctrl  out  4  to ALU ControlSig.
- alu_s  in  W  from ALU S.
- alu_zero  in  1  from ALU zero.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Values during reset: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_s=0, rsp_zero=0, alu_a=0, alu_b=0, alu_ctrl=0, busy=0.
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from pointer p, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that same cycle; the handshake completes then.
  - Operands, op and g are latched on that edge; next state is EXEC.
  - req_ready is 0 in every other state.
- EXEC:
  - alu_a/alu_b/alu_ctrl are driven from the latched registers.
  - At the edge, alu_s and alu_zero are captured into the result registers; next state is RESP.
  - The ALU is combinational, so one cycle suffices.
- RESP:
  - rsp_valid[g]=1; rsp_s and rsp_zero are held stable.
  - When rsp_ready[g]=1: go to IDLE and set p=(g+1) mod NREQ.
  - rsp_ready bits other than g are ignored.
- Latency and throughput:
  - Accept to rsp_valid is 2 cycles.
  - Minimum issue interval per op is 3 cycles (accept, exec, resp with immediate ready).
- Holding the ALU:
  - alu_* outputs hold their last driven value outside EXEC. They are not reset to 0 after the first operation.
- Requester rules:
  - A requester must keep req_valid and its operands stable until req_ready.
  - A requester may deassert req_valid before it is granted; it is then simply skipped.
- Simultaneous events:
  - A new req_valid arriving during EXEC/RESP waits; arbitration happens only in IDLE.
  - rsp_ready asserted in IDLE/EXEC has no effect.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 operations.
- Illegal op code: passed to the ALU unchanged; the result is whatever the ALU yields (no trap), unless the optional feature is compiled in.
- Reset asserted mid-operation: any in-flight op is discarded with no response, and all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0), valid alongside rsp_valid.
  - An op not in the legal set sets rsp_err=1 and forces rsp_s=0, rsp_zero=1. The ALU is still exercised, but its result is discarded.
  - rsp_err is cleared on the RESP handshake.
- Undefined: the port does not exist and no checking logic is present.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_t (4-bit);
  - constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111;
  - function alu_op_legal();
  - typedef arb_state_t {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter: NREQ-wide combinational round-robin grant from req vector and pointer, outputting one-hot grant plus index. It is reused later for the memory port.

Test Plan:
- Single op: req0 ADD a=8'h05 b=8'h03 -> req_ready[0] in cycle 0; rsp_valid[0] 2 cycles later with rsp_s=8'h08, rsp_zero=0.
- Zero flag: req1 SUB a=8'h2A b=8'h2A -> rsp_s=8'h00, rsp_zero=1. SLT a=8'h01 b=8'h02 -> rsp_s=8'h01.
- Contention: req0 and req1 both valid continuously with 4 ops each -> grants alternate 0,1,0,1,...; after reset the first grant goes to 0.
- Backpressure: hold rsp_ready[g]=0 for 5 cycles -> rsp_valid and rsp_s stable, busy=1, no req_ready asserted. Release -> IDLE next cycle.
- Reset mid-op: drop rst_n during EXEC -> rsp_valid=0 and busy=0 immediately; after release no stale response appears and p=0.
- With ALU_ARB_OPCHK_EN: req_op=4'b1111 -> rsp_err=1, rsp_s=0, rsp_zero=1. A following legal AND 8'hF0&8'h3C -> rsp_err=0, rsp_s=8'h30.
